packet_dispatcher: RTL and testbench

Front-end stage for the 8-entry address/port routing table. It runs the table's setup phase from a config handshake and accepts a byte-stream packet whose first byte is the destination address. It drives that address into the table and waits out the lookup latency, then forwards the buffered packet to one of 4 output ports.

---
 rtl/packet_dispatcher_if.sv | 48 ++++
 rtl/packet_dispatcher.sv | 155 +++++++++++++++
 tb/tb_packet_dispatcher.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_dispatcher_if.sv
// Bus bundle for packet_dispatcher: config handshake, input byte stream,
// routing-table side and 4-port output. STRAY_CNT_EN adds stray_cnt.
interface packet_dispatcher_if #(
  parameter int DATA_W = 8
);
  logic              cfg_valid;
  logic [DATA_W-1:0] cfg_addr;
  logic [1:0]        cfg_port;
  logic              cfg_ready;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_sop;
  logic              in_eop;
  logic              in_ready;
  logic [DATA_W-1:0] rt_address;
  logic [1:0]        rt_p;
  logic              rt_setup;
  logic [1:0]        rt_port;
  logic [3:0]        out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_eop;
  logic [3:0]        out_ready;
`ifdef STRAY_CNT_EN
  logic [7:0]        stray_cnt;
`endif

  // dispatcher side
  modport slave (
    input  cfg_valid, cfg_addr, cfg_port, in_valid, in_data, in_sop, in_eop,
    input  rt_port, out_ready,
    output cfg_ready, in_ready, rt_address, rt_p, rt_setup,
    output out_valid, out_data, out_eop
`ifdef STRAY_CNT_EN
    , output stray_cnt
`endif
  );

  // environment side (source, routing table, sinks)
  modport master (
    output cfg_valid, cfg_addr, cfg_port, in_valid, in_data, in_sop, in_eop,
    output rt_port, out_ready,
    input  cfg_ready, in_ready, rt_address, rt_p, rt_setup,
    input  out_valid, out_data, out_eop
`ifdef STRAY_CNT_EN
    , input stray_cnt
`endif
  );
endinterface

// File: rtl/packet_dispatcher.sv
// packet_dispatcher: drives the routing table setup from the config
// handshake, looks up the first byte of each packet in the table, buffers the
// packet in a FWFT FIFO and forwards it to the port the table returned.
// Optional macro STRAY_CNT_EN adds a saturating count of discarded stray bytes.
module packet_dispatcher #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int LOOKUP_LAT = 2
) (
  input logic             clk,
  input logic             reset,
  packet_dispatcher_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LOOKUP_LAT + 2);

  typedef enum logic [1:0] {IDLE, CFG, LOOKUP, FORWARD} state_t;

  state_t            state;
  logic [DATA_W-1:0] rt_address;
  logic [1:0]        rt_p;
  logic              rt_setup;
  logic [1:0]        sel;
  logic [CW-1:0]     wait_cnt;
  logic              eop_seen;

  logic [DATA_W:0]   mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, empty;
  logic [DATA_W:0]   head;

  logic              cfg_ready, in_ready, in_fire, push, pop, fwd_vld;
  logic [3:0]        out_valid;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Handshake readies: config wins in IDLE; once the packet's eop is in,
  // nothing more is taken until the dispatcher is back in IDLE.
  always_comb begin
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:            begin cfg_ready = bus.cfg_valid; in_ready = ~bus.cfg_valid; end
        LOOKUP, FORWARD: in_ready = ~full & ~eop_seen;
        default:         ;
      endcase
    end
  end

  assign in_fire   = bus.in_valid & in_ready;
  // in IDLE only a start-of-packet byte enters the FIFO; anything else is stray
  assign push      = in_fire & ((state != IDLE) | bus.in_sop);
  assign fwd_vld   = ~reset & (state == FORWARD) & ~empty;
  assign out_valid = fwd_vld ? (4'b0001 << sel) : 4'b0000;
  assign pop       = fwd_vld & bus.out_ready[sel];

  // Control FSM with registered table-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rt_address <= '0;
      rt_p       <= '0;
      rt_setup   <= 1'b0;
      sel        <= '0;
      wait_cnt   <= '0;
      eop_seen   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          eop_seen <= 1'b0;
          if (bus.cfg_valid) begin
            rt_address <= bus.cfg_addr;
            rt_p       <= bus.cfg_port;
            rt_setup   <= 1'b1;
            state      <= CFG;
          end else if (in_fire && bus.in_sop) begin
            rt_address <= bus.in_data;
            rt_setup   <= 1'b0;
            wait_cnt   <= '0;
            eop_seen   <= bus.in_eop;
            state      <= LOOKUP;
          end
        end
        CFG: begin
          rt_setup <= 1'b0;
          state    <= IDLE;
        end
        LOOKUP: begin
          if (in_fire && bus.in_eop) eop_seen <= 1'b1;
          // table output is valid once LOOKUP_LAT stages have seen rt_address
          if (wait_cnt == CW'(LOOKUP_LAT)) begin
            sel   <= bus.rt_port;
            state <= FORWARD;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        FORWARD: begin
          if (in_fire && bus.in_eop) eop_seen <= 1'b1;
          if (pop && head[DATA_W]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: {eop, data}
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_eop, bus.in_data};
  end

`ifdef STRAY_CNT_EN
  logic [7:0] stray_cnt;

  // Saturating count of non-sop bytes dropped while idle
  always_ff @(posedge clk) begin
    if (reset)
      stray_cnt <= '0;
    else if (state == IDLE && in_fire && !bus.in_sop && stray_cnt != 8'hFF)
      stray_cnt <= stray_cnt + 8'd1;
  end

  assign bus.stray_cnt = stray_cnt;
`endif

  assign bus.cfg_ready  = cfg_ready;
  assign bus.in_ready   = in_ready;
  assign bus.rt_address = rt_address;
  assign bus.rt_p       = rt_p;
  assign bus.rt_setup   = rt_setup;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = head[DATA_W-1:0];
  assign bus.out_eop    = head[DATA_W];
endmodule

// File: tb/tb_packet_dispatcher.sv
// Scoreboard bench for packet_dispatcher: the driver queues each accepted
// packet byte with the port the reference table predicts; a negedge monitor
// pops and compares on every output transfer.
module tb_packet_dispatcher;
  localparam int DATA_W = 8, DEPTH = 16, LOOKUP_LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  packet_dispatcher_if #(.DATA_W(DATA_W)) bus ();
  packet_dispatcher #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LOOKUP_LAT(LOOKUP_LAT))
    dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct {logic [1:0] port; logic [7:0] data; logic eop;} exp_t;
  exp_t sbq[$];

  int nchk = 0, nfail = 0, cyc = 0, occ = 0, sop_cyc = 0, cfg_acc_cnt = 0;
  int stray_sent = 0, ready_mode = 0, n_cfg = 0;
  bit lat_pending = 0, eop_acc = 0, full_seen = 0;
  logic [3:0] rdy_manual = 4'hF;
  logic [7:0] cur_hdr = 8'h00;

  // routing table behaviour: writes on setup, port appears LOOKUP_LAT clocks later
  logic [1:0] dut_tbl [logic [7:0]];
  logic [1:0] ref_tbl [logic [7:0]];
  logic [1:0] lk1 = 2'd0, lk2 = 2'd0;
  always @(posedge clk) begin
    if (bus.rt_setup === 1'b1) dut_tbl[bus.rt_address] = bus.rt_p;
    lk1 <= dut_tbl.exists(bus.rt_address) ? dut_tbl[bus.rt_address] : 2'd0;
    lk2 <= lk1;
  end
  assign bus.rt_port = lk2;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] ref_port(logic [7:0] a);
    return ref_tbl.exists(a) ? ref_tbl[a] : 2'd0;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // sink ready pattern
  initial begin
    bus.out_ready = 4'hF;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.out_ready = 4'hF;
        1:       bus.out_ready = 4'($urandom);
        default: bus.out_ready = rdy_manual;
      endcase
    end
  end

  // monitor / scoreboard checker
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.cfg_ready) cfg_acc_cnt++;
      if (bus.out_valid != 4'b0) begin
        if (sbq.size() == 0) chk("spurious_out_valid", 32'(bus.out_valid), 0);
        else begin
          if (lat_pending) begin
            chk("first_out_latency", cyc - sop_cyc, LOOKUP_LAT + 2);
            lat_pending = 0;
          end
          chk("rt_address_held", 32'(bus.rt_address), 32'(cur_hdr));
          chk("out_valid_port", 32'(bus.out_valid), 32'(4'b0001 << sbq[0].port));
          if ((bus.out_valid & bus.out_ready) != 4'b0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("out_data", 32'(bus.out_data), 32'(e.data));
            chk("out_eop", 32'(bus.out_eop), 32'(e.eop));
            occ--;
            if (e.eop) eop_acc = 0;
          end
        end
      end
      if (occ >= DEPTH) begin
        chk("in_ready_at_full", 32'(bus.in_ready), 0);
        full_seen = 1;
      end
      if (eop_acc) chk("in_ready_after_eop", 32'(bus.in_ready), 0);
    end
  end

  task automatic send_pkt(input logic [7:0] pkt[$], input int gap_pct);
    logic [1:0] p;
    int acc;
    bit ok;
    p = ref_port(pkt[0]);
    for (int i = 0; i < pkt.size(); i++) begin
      if (i > 0 && $urandom_range(99) < gap_pct) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = pkt[i];
      bus.in_sop   = (i == 0);
      bus.in_eop   = (i == pkt.size() - 1);
      ok = 0;
      acc = 0;
      for (int t = 0; t < 300; t++) begin
        @(negedge clk);
        if (bus.in_ready) begin ok = 1; acc = cyc; break; end
      end
      if (!ok) begin
        chk("in_ready_timeout", 0, 1);
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      sbq.push_back('{p, pkt[i], (i == pkt.size() - 1)});
      occ++;
      if (i == 0) begin cur_hdr = pkt[0]; sop_cyc = acc; lat_pending = 1; end
      if (i == pkt.size() - 1) eop_acc = 1;
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !eop_acc) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_cfg(input logic [7:0] a, input logic [1:0] p);
    bit ok = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_port  = p;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.cfg_ready) begin ok = 1; break; end
    end
    if (!ok) begin chk("cfg_ready_timeout", 0, 1); bus.cfg_valid = 1'b0; return; end
    chk("rt_setup_low_before_cfg", 32'(bus.rt_setup), 0);
    @(posedge clk);
    ref_tbl[a] = p;
    n_cfg++;
    #1;
    @(negedge clk);
    chk("rt_setup_pulse", 32'(bus.rt_setup), 1);
    chk("rt_address_cfg", 32'(bus.rt_address), 32'(a));
    chk("rt_p_cfg", 32'(bus.rt_p), 32'(p));
    chk("cfg_ready_in_cfg", 32'(bus.cfg_ready), 0);
    chk("in_ready_in_cfg", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sbq.delete();
    occ = 0; lat_pending = 0; eop_acc = 0;
    bus.in_valid = 1'b0; bus.cfg_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] pkt[$];
    int c0;
    bus.cfg_valid = 1'b1; bus.cfg_addr = '0; bus.cfg_port = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;

    // reset state, readies held low during reset even with cfg_valid up
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    bus.cfg_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rt_address", 32'(bus.rt_address), 0);
    chk("rst_rt_p", 32'(bus.rt_p), 0);
    chk("rst_rt_setup", 32'(bus.rt_setup), 0);
    chk("idle_in_ready", 32'(bus.in_ready), 1);
    chk("idle_cfg_ready", 32'(bus.cfg_ready), 0);
    @(posedge clk); #1;

    // three config entries, cfg_valid kept high across them
    cfg_acc_cnt = 0;
    do_cfg(8'h11, 2'd1);
    do_cfg(8'h22, 2'd2);
    do_cfg(8'h33, 2'd3);
    bus.cfg_valid = 1'b0;
    chk("cfg_ready_pulses", cfg_acc_cnt, 3);

    // short packet to port 2
    ready_mode = 0;
    pkt = '{8'h22, 8'hA1, 8'hB2};
    send_pkt(pkt, 0);
    wait_drain();
    @(negedge clk);
    chk("back_to_idle", 32'(bus.in_ready), 1);
    @(posedge clk); #1;

    // long packet to port 1 with the sink stalled long enough to fill the FIFO
    ready_mode = 2; rdy_manual = 4'b1101; full_seen = 0;
    pkt.delete();
    pkt.push_back(8'h11);
    for (int i = 1; i < 20; i++) pkt.push_back(8'(8'h40 + i));
    fork
      send_pkt(pkt, 0);
      begin
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          if (bus.out_valid != 4'b0) break;
        end
        repeat (14) @(posedge clk);
        #1 rdy_manual = 4'hF;
      end
    join
    wait_drain();
    chk("fifo_reached_full", 32'(full_seen), 1);

    // stray bytes then a packet to an unconfigured address
    ready_mode = 0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
      bus.in_data = (i == 0) ? 8'h55 : 8'h66;
      @(negedge clk);
      chk("stray_in_ready", 32'(bus.in_ready), 1);
      @(posedge clk); #1;
      stray_sent++;
    end
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pkt = '{8'h99, 8'h01, 8'h02};
    send_pkt(pkt, 0);
    wait_drain();
`ifdef STRAY_CNT_EN
    chk("stray_cnt", 32'(bus.stray_cnt), 2);
`endif

    // single-byte packet
    pkt = '{8'h33};
    send_pkt(pkt, 0);
    wait_drain();

    // reset mid-FORWARD with bytes still buffered
    ready_mode = 2; rdy_manual = 4'h0;
    pkt = '{8'h33, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    send_pkt(pkt, 0);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.out_valid != 4'b0) break;
    end
    @(posedge clk); #1 rdy_manual = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1 rdy_manual = 4'h0;
    do_reset();
    rdy_manual = 4'hF;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(bus.out_valid), 0);
    chk("post_rst_rt_setup", 32'(bus.rt_setup), 0);
    chk("post_rst_rt_address", 32'(bus.rt_address), 0);
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);
    repeat (3) @(negedge clk);
    chk("post_rst_fifo_empty", 32'(bus.out_valid), 0);
    @(posedge clk); #1;
    ready_mode = 0;
    pkt = '{8'h22, 8'hD1, 8'hD2};
    send_pkt(pkt, 0);
    wait_drain();

    // cfg and sop offered together: config wins, sop taken two cycles later
    bus.cfg_valid = 1'b1; bus.cfg_addr = 8'h44; bus.cfg_port = 2'd3;
    bus.in_valid = 1'b1; bus.in_sop = 1'b1; bus.in_eop = 1'b0; bus.in_data = 8'h44;
    @(negedge clk);
    c0 = cyc;
    chk("tie_cfg_ready", 32'(bus.cfg_ready), 1);
    chk("tie_in_ready", 32'(bus.in_ready), 0);
    @(posedge clk);
    ref_tbl[8'h44] = 2'd3;
    n_cfg++;
    #1 bus.cfg_valid = 1'b0;
    @(negedge clk);
    chk("tie_cfg_in_ready", 32'(bus.in_ready), 0);
    chk("tie_rt_setup", 32'(bus.rt_setup), 1);
    @(posedge clk); #1;
    pkt = '{8'h44, 8'hE1, 8'hE2, 8'hE3};
    send_pkt(pkt, 0);
    chk("tie_sop_delay", sop_cyc - c0, 2);
    wait_drain();

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      int act;
      ready_mode = $urandom_range(1);
      act = $urandom_range(9);
      if (act == 0 && n_cfg < 8) begin
        do_cfg(8'($urandom_range(8'h60, 8'h7F)), 2'($urandom));
        bus.cfg_valid = 1'b0;
      end else if (act == 1) begin
        bus.in_valid = 1'b1; bus.in_sop = 1'b0; bus.in_eop = 1'($urandom);
        bus.in_data = 8'($urandom);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        stray_sent++;
      end else begin
        int len;
        logic [7:0] dsts[5];
        dsts = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        dsts[4] = 8'($urandom);
        len = $urandom_range(1, 40);
        pkt.delete();
        pkt.push_back(dsts[$urandom_range(4)]);
        for (int i = 1; i < len; i++) pkt.push_back(8'($urandom));
        send_pkt(pkt, 20);
        wait_drain();
      end
    end
`ifdef STRAY_CNT_EN
    chk("stray_cnt_final", 32'(bus.stray_cnt), (stray_sent > 255) ? 255 : stray_sent);
`endif

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
